// File: rtl/tlul_gpio.sv
// TL-UL GPIO peripheral: pad synchronizer, output/direction registers and optional
// edge-triggered interrupts (built in when TLUL_GPIO_INTR_EN is defined).

package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

endpackage

module tlul_gpio #(
    parameter int NumGpio = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  tlul_pkg::tl_h2d_t  tl_i,
    output tlul_pkg::tl_d2h_t  tl_o,
    input  logic [31:0]        gpio_i,
    output logic [31:0]        gpio_o,
    output logic [31:0]        gpio_oe_o,
    output logic               intr_gpio_o
);
    import tlul_pkg::*;

    localparam logic [31:0] ImplMask = 32'hFFFF_FFFF >> (32 - NumGpio);

    typedef enum logic [4:0] {
        RegDataIn     = 5'h00,
        RegDataOut    = 5'h04,
        RegDir        = 5'h08,
        RegIntrState  = 5'h0C,
        RegIntrEnable = 5'h10,
        RegRiseEn     = 5'h14,
        RegFallEn     = 5'h18
    } regOffset_e;

    logic [31:0] r_sync1;
    logic [31:0] r_sync2;
    logic [31:0] r_dataOut;
    logic [31:0] r_dir;

    logic        r_rspValid;
    logic [2:0]  r_rspOpcode;
    logic [1:0]  r_rspSize;
    logic [7:0]  r_rspSource;
    logic [31:0] r_rspData;
    logic        r_rspError;

    logic        w_aReady;
    logic        w_accept;
    logic        w_isGet;
    logic        w_isPut;
    logic        w_hit;
    logic        w_writable;
    logic        w_error;
    logic        w_wrEn;
    logic [4:0]  w_offset;
    logic [31:0] w_byteMask;
    logic [31:0] w_wrBits;
    logic [31:0] w_readData;
    logic        w_unused;

`ifdef TLUL_GPIO_INTR_EN
    logic [31:0] r_sync3;
    logic [31:0] r_intrState;
    logic [31:0] r_intrEnable;
    logic [31:0] r_riseEn;
    logic [31:0] r_fallEn;
    logic [31:0] w_intrSet;
    logic [31:0] w_intrClr;
`endif

    assign w_aReady   = !r_rspValid || tl_i.d_ready;
    assign w_accept   = tl_i.a_valid && w_aReady;
    assign w_isGet    = (tl_i.a_opcode == Get);
    assign w_isPut    = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    assign w_offset   = tl_i.a_address[4:0];
    assign w_byteMask = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                         {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};
    assign w_wrBits   = w_byteMask & ImplMask;
    assign w_unused   = ^tl_i.a_param;

    // Address decode: anything outside the 32-byte window or misaligned is unmapped
    always_comb begin
        w_hit      = 1'b0;
        w_writable = 1'b0;
        w_readData = '0;
        if ((tl_i.a_address[31:5] == '0) && (tl_i.a_address[1:0] == 2'b00)) begin
            case (w_offset)
                RegDataIn:     begin w_hit = 1'b1; w_readData = r_sync2; end
                RegDataOut:    begin w_hit = 1'b1; w_writable = 1'b1; w_readData = r_dataOut; end
                RegDir:        begin w_hit = 1'b1; w_writable = 1'b1; w_readData = r_dir; end
`ifdef TLUL_GPIO_INTR_EN
                RegIntrState:  begin w_hit = 1'b1; w_writable = 1'b1; w_readData = r_intrState; end
                RegIntrEnable: begin w_hit = 1'b1; w_writable = 1'b1; w_readData = r_intrEnable; end
                RegRiseEn:     begin w_hit = 1'b1; w_writable = 1'b1; w_readData = r_riseEn; end
                RegFallEn:     begin w_hit = 1'b1; w_writable = 1'b1; w_readData = r_fallEn; end
`endif
                default: ;
            endcase
        end
    end

    assign w_error = !(w_hit && (w_isGet || (w_isPut && w_writable)));
    assign w_wrEn  = w_accept && w_isPut && !w_error;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_i & ImplMask;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dataOut <= '0;
            r_dir     <= '0;
        end else if (w_wrEn) begin
            if (w_offset == RegDataOut) r_dataOut <= (r_dataOut & ~w_wrBits) | (tl_i.a_data & w_wrBits);
            if (w_offset == RegDir)     r_dir     <= (r_dir & ~w_wrBits) | (tl_i.a_data & w_wrBits);
        end
    end

    // Response slot stays loaded until the host takes it with d_ready
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rspValid  <= 1'b0;
            r_rspOpcode <= '0;
            r_rspSize   <= '0;
            r_rspSource <= '0;
            r_rspData   <= '0;
            r_rspError  <= 1'b0;
        end else if (w_accept) begin
            r_rspValid  <= 1'b1;
            r_rspOpcode <= w_isGet ? AccessAckData : AccessAck;
            r_rspSize   <= tl_i.a_size;
            r_rspSource <= tl_i.a_source;
            r_rspData   <= (w_isGet && !w_error) ? w_readData : '0;
            r_rspError  <= w_error;
        end else if (tl_i.d_ready) begin
            r_rspValid  <= 1'b0;
        end
    end

`ifdef TLUL_GPIO_INTR_EN
    assign w_intrSet = (( r_sync2 & ~r_sync3 & r_riseEn) |
                        (~r_sync2 &  r_sync3 & r_fallEn)) & ImplMask;
    assign w_intrClr = (w_wrEn && (w_offset == RegIntrState)) ? (tl_i.a_data & w_wrBits) : '0;

    // Hardware set takes priority over a same-cycle software clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync3      <= '0;
            r_intrState  <= '0;
            r_intrEnable <= '0;
            r_riseEn     <= '0;
            r_fallEn     <= '0;
        end else begin
            r_sync3     <= r_sync2;
            r_intrState <= (r_intrState & ~w_intrClr) | w_intrSet;
            if (w_wrEn && (w_offset == RegIntrEnable))
                r_intrEnable <= (r_intrEnable & ~w_wrBits) | (tl_i.a_data & w_wrBits);
            if (w_wrEn && (w_offset == RegRiseEn))
                r_riseEn <= (r_riseEn & ~w_wrBits) | (tl_i.a_data & w_wrBits);
            if (w_wrEn && (w_offset == RegFallEn))
                r_fallEn <= (r_fallEn & ~w_wrBits) | (tl_i.a_data & w_wrBits);
        end
    end

    assign intr_gpio_o = |(r_intrState & r_intrEnable);
`else
    assign intr_gpio_o = 1'b0;
`endif

    assign gpio_o    = r_dataOut;
    assign gpio_oe_o = r_dir;

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = r_rspValid;
        tl_o.d_opcode = r_rspOpcode;
        tl_o.d_size   = r_rspSize;
        tl_o.d_source = r_rspSource;
        tl_o.d_data   = r_rspData;
        tl_o.d_error  = r_rspError;
        tl_o.a_ready  = w_aReady;
    end

endmodule

// File: doc/tlul_gpio.md
TLUL_GPIO -- requirements
Module: tlul_gpio

Interface
REQ-001 SHALL have parameter NumGpio, default 32, number of implemented GPIO bits (1..32); bits at and above NumGpio read 0 and ignore writes.
REQ-002 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tl_i  input  tlul_pkg::tl_h2d_t  TL-UL request from peripheral crossbar.
REQ-005 SHALL have port tl_o  output  tlul_pkg::tl_d2h_t  TL-UL response to peripheral crossbar.
REQ-006 SHALL have port gpio_i  input  32  pad input values, asynchronous to clk_i.
REQ-007 SHALL have port gpio_o  output  32  pad output values (DATA_OUT).
REQ-008 SHALL have port gpio_oe_o  output  32  pad output enables (DIR, 1 = drive).
REQ-009 SHALL have port intr_gpio_o  output  1  level interrupt.

Function
REQ-010 Register map, word offsets on a_address[4:0]: 0x00 DATA_IN RO; 0x04 DATA_OUT RW; 0x08 DIR RW; 0x0C INTR_STATE RW1C; 0x10 INTR_ENABLE RW; 0x14 INTR_RISE_EN RW; 0x18 INTR_FALL_EN RW.
REQ-011 Request accepted when a_valid && a_ready; a_ready = !rsp_valid || d_ready, giving one accepted request per cycle under continuous d_ready.
REQ-012 Response registered: d_valid rises the cycle after acceptance, d_source/d_size copied from the request, held stable until d_valid && d_ready.
REQ-013 Get (opcode 4) -> AccessAckData (1), d_data = register value at acceptance; PutFullData (0)/PutPartialData (1) -> AccessAck (0), d_data = 0.
REQ-014 Writes honour a_mask per byte; written value visible on gpio_o/gpio_oe_o the cycle after acceptance.
REQ-015 d_error = 1, no state change, d_data = 0 on: a_address[1:0] != 0, unmapped offset, any other opcode, or write to DATA_IN.
REQ-016 gpio_i passes a 2-flop synchronizer; DATA_IN = synchronizer output, so a pad change is readable 2 cycles later.
REQ-017 Edge detect compares synchronizer output to a third registered copy; rising edge on bit i with INTR_RISE_EN[i] sets INTR_STATE[i]; falling edge with INTR_FALL_EN[i] likewise.
REQ-018 INTR_STATE write clears bits written 1; simultaneous hardware set and software clear on a bit: set wins.
REQ-019 intr_gpio_o = |(INTR_STATE & INTR_ENABLE), combinational from registers.
REQ-020 Response held off (d_ready low) SHALL NOT lose or alter the pending response; edge detection continues meanwhile.

Reset
REQ-021 While rst_ni low: DATA_OUT, DIR, all INTR_* registers, synchronizer and edge flops = 0; d_valid = 0; a_ready = 1 after release.
REQ-022 Reset mid-transaction discards any pending response; no partial write survives.
REQ-023 First cycle after reset release SHALL NOT flag edges (edge flop reset equal to synchronizer reset).

Configuration
REQ-024 Macro TLUL_GPIO_INTR_EN: defined -> REQ-017..019 implemented as specified.
REQ-025 Macro TLUL_GPIO_INTR_EN undefined -> offsets 0x0C..0x18 unmapped (d_error = 1), edge logic absent, intr_gpio_o tied 0.

Verification
REQ-026 Reset, then Get 0x04 -> AccessAckData, d_data 0x0, d_error 0; gpio_o = 0, gpio_oe_o = 0.
REQ-027 PutFullData 0x04 data 0xA5A5_0000 mask 0xF, then PutPartialData 0x04 data 0x0000_00FF mask 0x1 -> gpio_o = 0xA5A5_00FF.
REQ-028 gpio_i bit 3 0->1 with INTR_RISE_EN = 0x8, INTR_ENABLE = 0x8 -> DATA_IN bit 3 = 1 after 2 cycles, INTR_STATE = 0x8, intr_gpio_o = 1; write 0x8 to 0x0C -> intr_gpio_o = 0.
REQ-029 Get 0x02 and Get 0x40 -> d_error 1, d_data 0, registers unchanged.
REQ-030 d_ready held low 5 cycles after a Get -> a_ready = 0, d_valid/d_data stable; back-to-back Gets with d_ready = 1 -> one response per cycle.
REQ-031 Same-cycle rising edge on bit 0 and INTR_STATE clear of bit 0 -> INTR_STATE bit 0 = 1.
